// File: rtl/hwloop_pkg.sv
// Shared types and constants for the zero-overhead hardware-loop controller.
package hwloop_pkg;

    localparam int HWL_NUM_LOOPS = 2;
    localparam int HWL_CNT_W     = 16;

    // Next-PC select code driven when the loop controller redirects fetch.
    localparam logic [1:0] PCSEL_HWLOOP = 2'd2;

    typedef enum logic {
        HWL_IDLE   = 1'b0,
        HWL_ACTIVE = 1'b1
    } hwl_state_t;

    // One loop descriptor as seen by software.
    typedef struct packed {
        logic [31:0]          start;
        logic [31:0]          end_addr;
        logic [HWL_CNT_W-1:0] cnt;
    } hwl_slot_t;

endpackage

// File: rtl/hwloop_slot.sv
// One hardware-loop slot: descriptor registers, IDLE/ACTIVE FSM,
// end-address match and iteration countdown.
//
//   state      | meaning
//   -----------+------------------------------------------------
//   HWL_IDLE   | no loop armed; slot accepts a setup
//   HWL_ACTIVE | loop armed; end-address compare enabled
module hwloop_slot
    import hwloop_pkg::*;
#(
    parameter int CNT_W = HWL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [31:0]      i_start,
    input  logic [31:0]      i_end,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_abort,
    input  logic             i_eval_en,
    input  logic             i_hit,
    input  logic [31:0]      i_pc,
    output logic             o_active,
    output logic             o_match,
    output logic             o_last,
    output logic [31:0]      o_start
);

    hwl_state_t       r_state;
    hwl_state_t       w_state_next;
    logic [31:0]      r_start;
    logic [31:0]      r_end;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HWL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a zero-count setup leaves the slot idle; i_hit is only
    // raised by the top for a qualified match, so abort never meets a hit.
    always_comb begin
        w_state_next = r_state;
        if (i_abort) begin
            w_state_next = HWL_IDLE;
        end else begin
            case (r_state)
                HWL_IDLE:   if (i_load && (i_count != '0)) w_state_next = HWL_ACTIVE;
                HWL_ACTIVE: if (i_hit && w_last)           w_state_next = HWL_IDLE;
                default:    w_state_next = HWL_IDLE;
            endcase
        end
    end

    // Outputs: end-address match and last-iteration flag for the priority chain.
    always_comb begin
        o_active = (r_state == HWL_ACTIVE);
        o_match  = (r_state == HWL_ACTIVE) && i_eval_en && (i_pc == r_end);
        o_last   = w_last;
        o_start  = r_start;
    end

    // Descriptor registers; the count stops at 1 on the jump path and only
    // the final hit takes it to 0, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= '0;
            r_end   <= '0;
            r_cnt   <= '0;
        end else if (i_abort) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_start <= i_start;
            r_end   <= i_end;
            r_cnt   <= i_count;
        end else if (i_hit) begin
            r_cnt <= w_last ? '0 : (r_cnt - CNT_W'(1));
        end
    end

endmodule

// File: rtl/hwloop_ctrl.sv
// Zero-overhead hardware-loop controller: holds nested loop descriptors,
// watches the fetch PC and requests a redirect to the loop start at the end
// address. Slot 0 is innermost and wins priority.
module hwloop_ctrl
    import hwloop_pkg::*;
#(
    parameter  int NUM_LOOPS = HWL_NUM_LOOPS,
    parameter  int CNT_W     = HWL_CNT_W,
    localparam int IDX_W     = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [31:0]          cfg_start,
    input  logic [31:0]          cfg_end,
    input  logic [CNT_W-1:0]     cfg_count,
    input  logic                 abort,
    input  logic [31:0]          pc,
    input  logic                 ena,
    input  logic                 redirect,
    output logic                 hwloop_jump,
    output logic [31:0]          pc_hwloop,
    output logic [NUM_LOOPS-1:0] loop_active,
    output logic [NUM_LOOPS-1:0] loop_done
);

    logic                 w_eval_en;
    logic                 w_accept;
    logic                 w_sel_idle;
    logic                 w_blocked;
    logic [NUM_LOOPS-1:0] w_active;
    logic [NUM_LOOPS-1:0] w_match;
    logic [NUM_LOOPS-1:0] w_last;
    logic [NUM_LOOPS-1:0] w_hit;
    logic [NUM_LOOPS-1:0] w_load;
    logic [31:0]          w_start [NUM_LOOPS];

    // A branch redirect or stalled fetch means the PC at the end address
    // is not really being consumed, so no loop bookkeeping happens.
    assign w_eval_en   = ena && !redirect && !abort;
    assign w_accept    = cfg_valid && cfg_ready;
    assign loop_active = w_active;

    for (genvar g = 0; g < NUM_LOOPS; g++) begin : g_slot
        localparam logic [IDX_W-1:0] SLOT_IDX = IDX_W'(g);

        assign w_load[g] = w_accept && (cfg_idx == SLOT_IDX);

        hwloop_slot #(
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_load    (w_load[g]),
            .i_start   (cfg_start),
            .i_end     (cfg_end),
            .i_count   (cfg_count),
            .i_abort   (abort),
            .i_eval_en (w_eval_en),
            .i_hit     (w_hit[g]),
            .i_pc      (pc),
            .o_active  (w_active[g]),
            .o_match   (w_match[g]),
            .o_last    (w_last[g]),
            .o_start   (w_start[g])
        );
    end

    // Setup handshake: the addressed slot must be idle and no abort pending.
    always_comb begin
        w_sel_idle = 1'b0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            if (cfg_idx == IDX_W'(i)) w_sel_idle = !w_active[i];
        end
        cfg_ready = w_sel_idle && !abort;
    end

    // Priority chain: a finishing slot falls through so an outer loop sharing
    // the end address can still jump; the first jumping slot stops the chain.
    always_comb begin
        w_blocked   = 1'b0;
        w_hit       = '0;
        loop_done   = '0;
        hwloop_jump = 1'b0;
        pc_hwloop   = '0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            if (w_match[i] && !w_blocked) begin
                w_hit[i] = 1'b1;
                if (w_last[i]) begin
                    loop_done[i] = 1'b1;
                end else begin
                    w_blocked   = 1'b1;
                    hwloop_jump = 1'b1;
                    pc_hwloop   = w_start[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_hwloop_ctrl.sv
// Directed bench for hwloop_ctrl with a scoreboard of expected outputs.
module tb_hwloop_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_idx;
    logic [31:0] cfg_start;
    logic [31:0] cfg_end;
    logic [15:0] cfg_count;
    logic        abort;
    logic [31:0] pc;
    logic        ena;
    logic        redirect;
    logic        hwloop_jump;
    logic [31:0] pc_hwloop;
    logic [1:0]  loop_active;
    logic [1:0]  loop_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic        jump;
        logic [31:0] tgt;
        logic [1:0]  act;
        logic [1:0]  done;
        logic        chk_rdy;
        logic        rdy;
    } exp_t;

    exp_t sb[$];

    hwloop_ctrl #(.NUM_LOOPS(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idx     (cfg_idx),
        .cfg_start   (cfg_start),
        .cfg_end     (cfg_end),
        .cfg_count   (cfg_count),
        .abort       (abort),
        .pc          (pc),
        .ena         (ena),
        .redirect    (redirect),
        .hwloop_jump (hwloop_jump),
        .pc_hwloop   (pc_hwloop),
        .loop_active (loop_active),
        .loop_done   (loop_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, string field, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
        end
    endtask

    task automatic push_exp(string tag, logic ej, logic [31:0] et, logic [1:0] ea,
                            logic [1:0] ed, logic cr, logic er);
        exp_t e;
        e.tag = tag; e.jump = ej; e.tgt = et; e.act = ea; e.done = ed;
        e.chk_rdy = cr; e.rdy = er;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "jump", {31'b0, hwloop_jump}, {31'b0, e.jump});
            chk(e.tag, "target", pc_hwloop, e.tgt);
            chk(e.tag, "active", {30'b0, loop_active}, {30'b0, e.act});
            chk(e.tag, "done", {30'b0, loop_done}, {30'b0, e.done});
            if (e.chk_rdy) chk(e.tag, "ready", {31'b0, cfg_ready}, {31'b0, e.rdy});
        end
    endtask

    task automatic set_cfg(logic idx, logic [31:0] st, logic [31:0] en, logic [15:0] cnt);
        cfg_idx = idx; cfg_start = st; cfg_end = en; cfg_count = cnt; cfg_valid = 1'b1;
    endtask

    // One fetch cycle: drive, expect, sample at the falling edge, then clock.
    task automatic step(string tag, logic [31:0] p, logic en, logic rd, logic ab,
                        logic ej, logic [31:0] et, logic [1:0] ea, logic [1:0] ed, logic er);
        pc = p; ena = en; redirect = rd; abort = ab;
        push_exp(tag, ej, et, ea, ed, cfg_valid, er);
        @(negedge clk);
        pop_cmp();
        @(posedge clk);
        #1;
        cfg_valid = 1'b0; abort = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_start = '0; cfg_end = '0;
        cfg_count = '0; abort = 1'b0; pc = '0; ena = 1'b0; redirect = 1'b0;
        #2;
        push_exp("reset", 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1);
        pop_cmp();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single loop, count 3.
        set_cfg(1'b0, 32'h100, 32'h10C, 16'd3);
        step("t1_cfg", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1);
        for (int v = 0; v < 3; v++) begin
            for (int a = 32'h100; a < 32'h10C; a += 4)
                step("t1_body", 32'(a), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b0);
            step("t1_end", 32'h10C, 1'b1, 1'b0, 1'b0, (v < 2), (v < 2) ? 32'h100 : 32'h0,
                 2'b01, (v == 2) ? 2'b01 : 2'b00, 1'b0);
        end
        step("t1_after", 32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0);

        // Nested: outer slot 1 0x100-0x120 x2, inner slot 0 0x108-0x110 x2
        // re-armed by a setup at 0x104 on each outer pass.
        set_cfg(1'b1, 32'h100, 32'h120, 16'd2);
        step("t2_cfg1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1);
        for (int it = 0; it < 2; it++) begin
            step("t2_100", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 2'b00, 1'b0);
            set_cfg(1'b0, 32'h108, 32'h110, 16'd2);
            step("t2_104", 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 2'b00, 1'b1);
            for (int b = 0; b < 2; b++) begin
                step("t2_108", 32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b11, 2'b00, 1'b0);
                step("t2_10C", 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b11, 2'b00, 1'b0);
                step("t2_110", 32'h110, 1'b1, 1'b0, 1'b0, (b == 0), (b == 0) ? 32'h108 : 32'h0,
                     2'b11, (b == 1) ? 2'b01 : 2'b00, 1'b0);
            end
            for (int a = 32'h114; a < 32'h120; a += 4)
                step("t2_tail", 32'(a), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 2'b00, 1'b0);
            step("t2_120", 32'h120, 1'b1, 1'b0, 1'b0, (it == 0), (it == 0) ? 32'h100 : 32'h0,
                 2'b10, (it == 1) ? 2'b10 : 2'b00, 1'b0);
        end
        step("t2_after", 32'h124, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0);

        // Shared end address: inner finishes while outer jumps in the same cycle.
        set_cfg(1'b0, 32'h108, 32'h110, 16'd1);
        step("t3_cfg0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1);
        set_cfg(1'b1, 32'h100, 32'h110, 16'd3);
        step("t3_cfg1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b1);
        step("t3_shared", 32'h110, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 2'b11, 2'b01, 1'b0);
        step("t3_outer2", 32'h110, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 2'b10, 2'b00, 1'b0);
        step("t3_outer3", 32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 2'b10, 1'b0);
        step("t3_after", 32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0);

        // Redirect and stalled fetch suppress the match without consuming a count.
        set_cfg(1'b0, 32'h200, 32'h20C, 16'd2);
        step("t4_cfg", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1);
        step("t4_redir", 32'h20C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b0);
        step("t4_stall", 32'h20C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b0);
        step("t4_jump", 32'h20C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 2'b01, 2'b00, 1'b0);
        set_cfg(1'b1, 32'h800, 32'h80C, 16'd1);
        step("t4_done_cfg", 32'h20C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b01, 1'b1);
        step("t4_slot1", 32'h80C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 2'b10, 1'b0);
        step("t4_after", 32'h80C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0);

        // Setup to a busy slot, zero-count setup, abort beating a setup.
        set_cfg(1'b0, 32'h300, 32'h30C, 16'd5);
        step("t5_cfg", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1);
        set_cfg(1'b0, 32'h400, 32'h40C, 16'd7);
        step("t5_busy", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b0);
        step("t5_notstored", 32'h40C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b0);
        step("t5_orig", 32'h30C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 2'b01, 2'b00, 1'b0);
        set_cfg(1'b1, 32'h500, 32'h50C, 16'd0);
        step("t5_cnt0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b1);
        step("t5_cnt0_idle", 32'h50C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b0);
        set_cfg(1'b1, 32'h600, 32'h60C, 16'd4);
        step("t5_abort", 32'h30C, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 2'b00, 1'b0);
        step("t5_post_abort1", 32'h60C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0);
        step("t5_post_abort0", 32'h30C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        set_cfg(1'b0, 32'h700, 32'h70C, 16'd3);
        step("t6_cfg0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1);
        set_cfg(1'b1, 32'h700, 32'h70C, 16'd3);
        step("t6_cfg1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 2'b00, 1'b1);
        pc = 32'h70C; ena = 1'b1;
        #2;
        push_exp("t6_pre_rst", 1'b1, 32'h700, 2'b11, 2'b00, 1'b0, 1'b0);
        pop_cmp();
        rst = 1'b1;
        #1;
        push_exp("t6_async_rst", 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1);
        pop_cmp();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("t6_after", 32'h70C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
